// File: rtl/adder_arbiter_pkg.sv
// adder_arbiter_pkg: shared types and constants for the adder arbiter slice.
//   state_e : arbiter FSM states (IDLE, CALC, RESP)
//   NREQ    : number of requesters sharing the adder
//   CNT_W   : width of the completed-response counter
package adder_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int NREQ  = 2;
  localparam int CNT_W = 8;

endpackage

// File: rtl/adder_core.sv
// adder_core: shared combinational adder datapath.
//   a, b : WIDTH-bit operands
//   sum  : WIDTH+1-bit result, carry in the MSB (no truncation)
module adder_core #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum
);

  // Widen both operands so the carry lands in the MSB.
  assign sum = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter that shares one adder_core between two
// requesters and returns the registered sum on a valid/ready channel.
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid[1:0]       : requester i presents operands
//   req_a0/b0, req_a1/b1 : operands of requester 0 / 1
//   req_ready[1:0]       : requester i accepted this cycle (IDLE only)
//   rsp_valid/id/sum     : response channel, held until rsp_ready
//   rsp_ready            : consumer accepts the response
//   ops_done             : completed-response counter, wraps silently
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [WIDTH-1:0]  req_a0,
  input  logic [WIDTH-1:0]  req_b0,
  input  logic [WIDTH-1:0]  req_a1,
  input  logic [WIDTH-1:0]  req_b1,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [WIDTH:0]    rsp_sum,
  input  logic              rsp_ready,
  output logic [CNT_W-1:0]  ops_done
);

  state_e             state_r;
  state_e             state_nxt_s;
  logic               rr_r;
  logic               id_r;
  logic [WIDTH-1:0]   op_a_r;
  logic [WIDTH-1:0]   op_b_r;
  logic [WIDTH:0]     sum_r;
  logic [WIDTH:0]     core_sum_s;
  logic [CNT_W-1:0]   cnt_r;
  logic               grant_s;
  logic               grant_vld_s;
  logic               rsp_hs_s;

  adder_core #(.WIDTH(WIDTH)) u_core (
    .a   (op_a_r),
    .b   (op_b_r),
    .sum (core_sum_s)
  );

  assign rsp_hs_s = (state_r == RESP) && rsp_ready;

  // Arbitration, ready generation and next-state selection.
  always_comb begin
    state_nxt_s = state_r;
    grant_s     = 1'b0;
    grant_vld_s = 1'b0;
    req_ready   = {NREQ{1'b0}};
    case (state_r)
      IDLE: begin
        case (req_valid)
          2'b01: begin
            grant_vld_s = 1'b1;
            grant_s     = 1'b0;
          end
          2'b10: begin
            grant_vld_s = 1'b1;
            grant_s     = 1'b1;
          end
          2'b11: begin
            // Contention: the round-robin pointer picks the winner.
            grant_vld_s = 1'b1;
            grant_s     = rr_r;
          end
          default: begin
            grant_vld_s = 1'b0;
            grant_s     = 1'b0;
          end
        endcase
        if (grant_vld_s) begin
          req_ready[grant_s] = 1'b1;
          state_nxt_s        = CALC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        state_nxt_s = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand and owner capture on acceptance, sum capture in CALC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_r <= {WIDTH{1'b0}};
      op_b_r <= {WIDTH{1'b0}};
      id_r   <= 1'b0;
      sum_r  <= {(WIDTH+1){1'b0}};
    end else begin
      if (grant_vld_s) begin
        op_a_r <= grant_s ? req_a1 : req_a0;
        op_b_r <= grant_s ? req_b1 : req_b0;
        id_r   <= grant_s;
      end
      if (state_r == CALC) begin
        sum_r <= core_sum_s;
      end
    end
  end

  // Completion counter and round-robin pointer update on the response handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
      rr_r  <= 1'b0;
    end else if (rsp_hs_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
      rr_r  <= ~id_r;
    end
  end

  assign rsp_valid = (state_r == RESP);
  assign rsp_id    = id_r;
  assign rsp_sum   = sum_r;
  assign ops_done  = cnt_r;

endmodule
